// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequences CPU fetches and debug reads onto a 1-cycle-latency
// instruction memory. Define IMEM_FETCH_DBG_PORT_EN to enable the debug read path.
module imem_fetch_ctrl #(
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 24,
  parameter int                MEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              fetch_fault,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    F_ISSUE = 3'd1,
    F_CAPT  = 3'd2,
    D_ISSUE = 3'd3,
    D_CAPT  = 3'd4
  } state_t;

  // Last start address that still leaves room for a whole 3-byte word.
  localparam logic [ADDR_W-1:0] MAX_PC      = ADDR_W'(MEM_BYTES) - ADDR_W'(2'd3);
  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(2'd3);

  state_t              state_r;
  state_t              state_s;
  logic                grant_f_s;
  logic                grant_d_s;
  logic                dbg_req_s;
  logic [ADDR_W-1:0]   pc_eff_s;
  logic                fault_s;
  logic                dbg_oor_s;
  logic                capt_s;

  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   instr_r;
  logic [ADDR_W-1:0]   instr_pc_r;
  logic                fetch_valid_r;
  logic                fetch_fault_r;
  logic                busy_r;
  logic                pend_r;
  logic [ADDR_W-1:0]   pend_val_r;
  logic                last_grant_r;   // 1 = debug was granted last
  logic                oor_r;

  // A load in IDLE takes effect at once, so a simultaneous fetch uses the new target.
  assign pc_eff_s  = pc_load ? pc_load_value : pc_r;
  assign fault_s   = (pc_eff_s > MAX_PC);
  assign dbg_oor_s = (dbg_addr > MAX_PC);
  assign capt_s    = (state_r == F_CAPT) || (state_r == D_CAPT);

  // Next-state and grant decode.
  always_comb begin
    state_s   = state_r;
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_req && (!dbg_req_s || last_grant_r)) begin
          grant_f_s = 1'b1;
          state_s   = fault_s ? F_CAPT : F_ISSUE;
        end else if (dbg_req_s) begin
          grant_d_s = 1'b1;
          state_s   = dbg_oor_s ? D_CAPT : D_ISSUE;
        end else begin
          state_s   = IDLE;
        end
      end
      F_ISSUE: state_s = F_CAPT;
      F_CAPT:  state_s = IDLE;
      D_ISSUE: state_s = D_CAPT;
      D_CAPT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, PC, pending load, memory address and fetch result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      mem_addr_r    <= '0;
      instr_r       <= '0;
      instr_pc_r    <= '0;
      fetch_valid_r <= 1'b0;
      fetch_fault_r <= 1'b0;
      busy_r        <= 1'b0;
      pend_r        <= 1'b0;
      pend_val_r    <= '0;
      last_grant_r  <= 1'b1;
      oor_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s != IDLE);
      fetch_valid_r <= (state_r == F_CAPT);
      fetch_fault_r <= (state_r == F_CAPT) && oor_r;

      // Out-of-range grants skip the issue cycle and leave mem_addr untouched.
      if (grant_f_s) begin
        last_grant_r <= 1'b0;
        oor_r        <= fault_s;
        if (!fault_s) begin
          mem_addr_r <= pc_eff_s;
        end
      end else if (grant_d_s) begin
        last_grant_r <= 1'b1;
        oor_r        <= dbg_oor_s;
        if (!dbg_oor_s) begin
          mem_addr_r <= dbg_addr;
        end
      end

      if (state_r == F_CAPT) begin
        instr_r    <= oor_r ? '0 : mem_rd_data;
        instr_pc_r <= pc_r;
      end

      if (state_r == IDLE) begin
        if (pc_load) begin
          pc_r <= pc_load_value;
        end
      end else if (capt_s) begin
        // A load seen in the capture cycle itself is the newest and wins.
        if (pc_load) begin
          pc_r <= pc_load_value;
        end else if (pend_r) begin
          pc_r <= pend_val_r;
        end else if ((state_r == F_CAPT) && !oor_r) begin
          pc_r <= pc_r + INSTR_BYTES;
        end
        pend_r <= 1'b0;
      end else if (pc_load) begin
        pend_r     <= 1'b1;
        pend_val_r <= pc_load_value;
      end
    end
  end

`ifdef IMEM_FETCH_DBG_PORT_EN
  logic [DATA_W-1:0] dbg_data_r;
  logic              dbg_valid_r;

  assign dbg_req_s = dbg_req;

  // Debug read result and pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_data_r  <= '0;
      dbg_valid_r <= 1'b0;
    end else begin
      dbg_valid_r <= (state_r == D_CAPT);
      if (state_r == D_CAPT) begin
        dbg_data_r <= oor_r ? '0 : mem_rd_data;
      end
    end
  end

  assign dbg_data  = dbg_data_r;
  assign dbg_valid = dbg_valid_r;
`else
  logic unused_dbg_s;

  assign dbg_req_s    = 1'b0;
  assign unused_dbg_s = dbg_req;
  assign dbg_data     = '0;
  assign dbg_valid    = 1'b0;
`endif

  assign mem_addr    = mem_addr_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign pc          = pc_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_fault = fetch_fault_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed stimulus pushes expected results,
// a monitor pops and compares on every fetch_valid / dbg_valid pulse.
module tb_imem_fetch_ctrl;

  localparam int AW = 24;
  localparam int DW = 24;
  localparam int MB = 1024;
  localparam logic [AW-1:0] RST_PC = 24'h000000;

  typedef struct packed {
    logic          dbg;
    logic [DW-1:0] data;
    logic [AW-1:0] ipc;
    logic [AW-1:0] pc;
    logic          fault;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic          pc_load;
  logic [AW-1:0] pc_load_value;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] mem_rd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc;
  logic          fetch_valid;
  logic          fetch_fault;
  logic [DW-1:0] dbg_data;
  logic          dbg_valid;
  logic          busy;

  logic [7:0] mem [0:MB-1];
  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .mem_rd_data(mem_rd_data), .mem_addr(mem_addr), .instr(instr),
    .instr_pc(instr_pc), .pc(pc), .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault), .dbg_data(dbg_data), .dbg_valid(dbg_valid),
    .busy(busy)
  );

  function automatic logic [DW-1:0] rd3(input logic [AW-1:0] a);
    int i;
    i = int'(a);
    if (i + 2 < MB) return {mem[i], mem[i+1], mem[i+2]};
    else            return '0;
  endfunction

  // Big-endian 3-byte memory with one cycle of registered read latency.
  always @(posedge clk) mem_rd_data <= rd3(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic d, input logic [DW-1:0] data, input logic [AW-1:0] ipc,
                          input logic [AW-1:0] epc, input logic f);
    exp_t e;
    e.dbg = d; e.data = data; e.ipc = ipc; e.pc = epc; e.fault = f;
    sb_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_valid || dbg_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("valid_kind", {31'd0, dbg_valid}, {31'd0, e.dbg});
          if (e.dbg) begin
            chk("dbg_data", 32'(dbg_data), 32'(e.data));
            chk("dbg_pc", 32'(pc), 32'(e.pc));
            chk("dbg_no_fault", {31'd0, fetch_fault}, 32'd0);
          end else begin
            chk("instr", 32'(instr), 32'(e.data));
            chk("instr_pc", 32'(instr_pc), 32'(e.ipc));
            chk("pc", 32'(pc), 32'(e.pc));
            chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
          end
        end
      end
    end
  endtask

  // ld_cyc: -1 no load, 0 load with the request, n>0 load during the cycle after edge n.
  task automatic do_fetch(input int ld_cyc, input logic [AW-1:0] ldv, input logic [DW-1:0] ed,
                          input logic [AW-1:0] eipc, input logic [AW-1:0] epc, input logic ef,
                          input int elat);
    int n;
    logic seen;
    push_exp(1'b0, ed, eipc, epc, ef);
    n = 0;
    seen = 1'b0;
    fetch_req = 1'b1;
    pc_load = (ld_cyc == 0);
    pc_load_value = ldv;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      pc_load = (n == ld_cyc);
      seen = fetch_valid;
    end
    fetch_req = 1'b0;
    pc_load = 1'b0;
    chk("fetch_latency", 32'(n), 32'(elat));
  endtask

  task automatic load_idle(input logic [AW-1:0] v);
    pc_load = 1'b1;
    pc_load_value = v;
    @(posedge clk);
    @(negedge clk);
    pc_load = 1'b0;
    chk("pc_after_idle_load", 32'(pc), 32'(v));
  endtask

  task automatic wait_pulses(input logic d, input int cnt);
    int seen;
    int n;
    seen = 0;
    n = 0;
    while (seen < cnt && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (d ? dbg_valid : fetch_valid) seen++;
    end
    if (d) dbg_req = 1'b0;
    else   fetch_req = 1'b0;
    chk(d ? "dbg_pulse_count" : "fetch_pulse_count", 32'(seen), 32'(cnt));
  endtask

  initial begin
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h2B; mem[2] = 8'hFF;
    mem[3] = 8'h1E; mem[4] = 8'h28; mem[5] = 8'h01;
    mem[6] = 8'h55; mem[7] = 8'h66; mem[8] = 8'h77;
    mem[1021] = 8'hAA; mem[1022] = 8'hBB; mem[1023] = 8'hCC;

    reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    dbg_req = 1'b0; dbg_addr = '0;

    fork
      monitor_loop();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_pc", 32'(pc), 32'(RST_PC));
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_dbg_data", 32'(dbg_data), 32'd0);
    chk("rst_flags", {28'd0, fetch_valid, fetch_fault, dbg_valid, busy}, 32'd0);

    // Sequential fetches, then a load together with a fetch in IDLE.
    do_fetch(-1, 24'h0, 24'h102BFF, 24'h000000, 24'h000003, 1'b0, 3);
    do_fetch(-1, 24'h0, 24'h1E2801, 24'h000003, 24'h000006, 1'b0, 3);
    do_fetch(0, 24'h000003, 24'h1E2801, 24'h000003, 24'h000006, 1'b0, 3);

    // Last in-range address, then first out-of-range address.
    load_idle(24'h0003FD);
    do_fetch(-1, 24'h0, 24'hAABBCC, 24'h0003FD, 24'h000400, 1'b0, 3);
    load_idle(24'h0003FE);
    do_fetch(-1, 24'h0, 24'h000000, 24'h0003FE, 24'h0003FE, 1'b1, 2);
    chk("fault_no_mem_access", 32'(mem_addr), 32'h0003FD);

    // Load while busy replaces the increment.
    load_idle(24'h000006);
    do_fetch(1, 24'h000000, 24'h556677, 24'h000006, 24'h000000, 1'b0, 3);

    // Reset in the capture cycle aborts the fetch.
    fetch_req = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("busy_in_capt", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    fetch_req = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("abort_pc", 32'(pc), 32'(RST_PC));
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_instr", 32'(instr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_no_valid", {31'd0, fetch_valid}, 32'd0);
    end

`ifdef IMEM_FETCH_DBG_PORT_EN
    // Both requests held: fetch, debug, fetch.
    push_exp(1'b0, 24'h102BFF, 24'h000000, 24'h000003, 1'b0);
    push_exp(1'b1, 24'h102BFF, 24'h000000, 24'h000003, 1'b0);
    push_exp(1'b0, 24'h1E2801, 24'h000003, 24'h000006, 1'b0);
    dbg_addr = 24'h000000;
    fork
      begin fetch_req = 1'b1; wait_pulses(1'b0, 2); end
      begin dbg_req = 1'b1; wait_pulses(1'b1, 1); end
    join
    // Out-of-range debug read returns zero without a fault or memory access.
    push_exp(1'b1, 24'h000000, 24'h000000, 24'h000006, 1'b0);
    dbg_addr = 24'h0003FE;
    dbg_req = 1'b1;
    wait_pulses(1'b1, 1);
    chk("dbg_oor_no_mem_access", 32'(mem_addr), 32'h000003);
`else
    // Debug port disabled: held dbg_req is ignored, fetches proceed back to back.
    push_exp(1'b0, 24'h102BFF, 24'h000000, 24'h000003, 1'b0);
    push_exp(1'b0, 24'h1E2801, 24'h000003, 24'h000006, 1'b0);
    dbg_addr = 24'h000000;
    dbg_req = 1'b1;
    fetch_req = 1'b1;
    wait_pulses(1'b0, 2);
    dbg_req = 1'b0;
    chk("dbg_data_tied", 32'(dbg_data), 32'd0);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
